// File: rtl/compositor_pkg.sv
// Shared types and constants for the sprite layer compositor.
package compositor_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

  localparam rgb_t DEFAULT_KEY = 24'h00FF00;
  localparam rgb_t FLASH_RGB   = 24'hFFFFFF;

endpackage

// File: rtl/palette_ram.sv
// Register-file palette: one synchronous write port, RD_PORTS registered read ports.
module palette_ram
  import compositor_pkg::*;
#(
  parameter int IDX_W    = 4,
  parameter int RD_PORTS = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  rgb_t             i_wdata,
  input  logic [IDX_W-1:0] i_raddr [RD_PORTS],
  output rgb_t             o_rdata [RD_PORTS]
);

  localparam int DEPTH = 2 ** IDX_W;

  rgb_t r_mem   [DEPTH];
  rgb_t r_rdata [RD_PORTS];

  // Reads sample the array before this edge's write lands, so a same-cycle
  // lookup of the written entry returns the old colour.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      for (int p = 0; p < RD_PORTS; p++) r_rdata[p] <= '0;
    end else begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      for (int p = 0; p < RD_PORTS; p++) r_rdata[p] <= r_mem[i_raddr[p]];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite compositor: palette lookup, then priority/transparency
// selection with an optional per-layer flash effect.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int  NUM_LAYERS   = 4,
  parameter int  IDX_W        = 4,
  parameter int  FLASH_FRAMES = 8,
  localparam int LAYER_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int CNT_W        = $clog2(FLASH_FRAMES + 1)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        pix_valid,
  input  logic                        frame_start,
  input  logic [NUM_LAYERS-1:0]       layer_hit,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic [IDX_W-1:0]            bg_idx,
  input  logic                        pal_we,
  input  logic                        pal_sel,
  input  logic [IDX_W-1:0]            pal_addr,
  input  logic [23:0]                 pal_wdata,
  input  logic                        key_we,
  input  logic [23:0]                 key_wdata,
  input  logic                        flash_start,
  input  logic [LAYER_W-1:0]          flash_layer,
  output logic                        flash_busy,
  output logic                        out_valid,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B
);

  rgb_t               r_key;
  flash_state_t       r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [LAYER_W-1:0] r_flash_layer;
  logic               w_start_ok;

  logic [IDX_W-1:0]   w_spr_raddr [NUM_LAYERS];
  logic [IDX_W-1:0]   w_bg_raddr  [1];
  rgb_t               w_spr_col_p1 [NUM_LAYERS];
  rgb_t               w_bg_col_p1  [1];

  logic [NUM_LAYERS-1:0] r_hit_p1;
  logic                  r_vld_p1;
  logic                  r_flash_on_p1;
  logic [LAYER_W-1:0]    r_flash_layer_p1;

  logic               w_pick_hit;
  logic [LAYER_W-1:0] w_pick_layer;
  rgb_t               w_pick_col;
  rgb_t               r_rgb_p2;
  logic               r_vld_p2;

  always_ff @(posedge Clk) begin
    if (Reset)       r_key <= DEFAULT_KEY;
    else if (key_we) r_key <= key_wdata;
  end

  // Out-of-range layer numbers are dropped before they reach the FSM.
  assign w_start_ok = flash_start && (int'(flash_layer) < NUM_LAYERS);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_flash_layer <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_flash_layer <= flash_layer;
            r_cnt         <= CNT_W'(FLASH_FRAMES);
            r_state       <= FLASH;
          end
        end
        FLASH: begin
          if (w_start_ok) begin
            r_flash_layer <= flash_layer;
            r_cnt         <= CNT_W'(FLASH_FRAMES);
          end else if (frame_start) begin
            if (r_cnt == CNT_W'(1)) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign flash_busy = (r_state == FLASH);

  // Stage 1: palette lookups plus the control that must stay aligned with them
  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) w_spr_raddr[i] = layer_idx[i*IDX_W +: IDX_W];
    w_bg_raddr[0] = bg_idx;
  end

  palette_ram #(.IDX_W(IDX_W), .RD_PORTS(NUM_LAYERS)) u_spr_pal (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_we    (pal_we && pal_sel),
    .i_waddr (pal_addr),
    .i_wdata (pal_wdata),
    .i_raddr (w_spr_raddr),
    .o_rdata (w_spr_col_p1)
  );

  palette_ram #(.IDX_W(IDX_W), .RD_PORTS(1)) u_bg_pal (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_we    (pal_we && !pal_sel),
    .i_waddr (pal_addr),
    .i_wdata (pal_wdata),
    .i_raddr (w_bg_raddr),
    .o_rdata (w_bg_col_p1)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hit_p1         <= '0;
      r_vld_p1         <= 1'b0;
      r_flash_on_p1    <= 1'b0;
      r_flash_layer_p1 <= '0;
    end else begin
      r_hit_p1         <= layer_hit;
      r_vld_p1         <= pix_valid;
      r_flash_on_p1    <= (r_state == FLASH) && r_cnt[0];
      r_flash_layer_p1 <= r_flash_layer;
    end
  end

  // Stage 2: lowest-numbered opaque hit wins, background otherwise
  always_comb begin
    w_pick_hit   = 1'b0;
    w_pick_layer = '0;
    w_pick_col   = w_bg_col_p1[0];
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (r_hit_p1[i] && (w_spr_col_p1[i] != r_key)) begin
        w_pick_hit   = 1'b1;
        w_pick_layer = LAYER_W'(i);
        w_pick_col   = w_spr_col_p1[i];
      end
    end
    if (w_pick_hit && r_flash_on_p1 && (w_pick_layer == r_flash_layer_p1))
      w_pick_col = FLASH_RGB;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rgb_p2 <= '0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_rgb_p2 <= r_vld_p1 ? w_pick_col : '0;
      r_vld_p2 <= r_vld_p1;
    end
  end

  assign out_valid = r_vld_p2;
  assign VGA_R     = r_rgb_p2[23:16];
  assign VGA_G     = r_rgb_p2[15:8];
  assign VGA_B     = r_rgb_p2[7:0];

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor with a queue-based scoreboard.
module tb_layer_compositor;
  import compositor_pkg::*;

  localparam int NL = 4;
  localparam int IW = 4;
  localparam int FF = 8;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          pix_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [NL-1:0] layer_hit = '0;
  logic [NL*IW-1:0] layer_idx = '0;
  logic [IW-1:0] bg_idx = '0;
  logic          pal_we = 1'b0;
  logic          pal_sel = 1'b0;
  logic [IW-1:0] pal_addr = '0;
  logic [23:0]   pal_wdata = '0;
  logic          key_we = 1'b0;
  logic [23:0]   key_wdata = '0;
  logic          flash_start = 1'b0;
  logic [1:0]    flash_layer = '0;
  logic          flash_busy;
  logic          out_valid;
  logic [7:0]    VGA_R, VGA_G, VGA_B;

  layer_compositor #(.NUM_LAYERS(NL), .IDX_W(IW), .FLASH_FRAMES(FF)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .layer_hit   (layer_hit),
    .layer_idx   (layer_idx),
    .bg_idx      (bg_idx),
    .pal_we      (pal_we),
    .pal_sel     (pal_sel),
    .pal_addr    (pal_addr),
    .pal_wdata   (pal_wdata),
    .key_we      (key_we),
    .key_wdata   (key_wdata),
    .flash_start (flash_start),
    .flash_layer (flash_layer),
    .flash_busy  (flash_busy),
    .out_valid   (out_valid),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct {
    logic [23:0] rgb;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented pixel must match the head of the scoreboard
  // and arrive exactly two cycles after it was issued.
  always @(negedge Clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pixel: got %02h%02h%02h required no output", VGA_R, VGA_G, VGA_B);
        end else begin
          e = sbq.pop_front();
          check("pixel_rgb", {8'h00, VGA_R, VGA_G, VGA_B}, {8'h00, e.rgb});
          check("pixel_latency", cyc, e.cyc + 2);
        end
      end else begin
        check("blanking", {8'h00, VGA_R, VGA_G, VGA_B}, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pal_write(input logic sel, input logic [IW-1:0] a, input logic [23:0] d);
    pal_we = 1'b1; pal_sel = sel; pal_addr = a; pal_wdata = d;
    tick();
    pal_we = 1'b0;
  endtask

  task automatic pix(input logic [NL-1:0] hit, input logic [IW-1:0] i0, input logic [IW-1:0] i1,
                     input logic [IW-1:0] i2, input logic [IW-1:0] i3, input logic [IW-1:0] bg,
                     input logic [23:0] exp);
    exp_t e;
    pix_valid = 1'b1; layer_hit = hit; layer_idx = {i3, i2, i1, i0}; bg_idx = bg;
    e.rgb = exp; e.cyc = cyc;
    sbq.push_back(e);
    tick();
    pix_valid = 1'b0; layer_hit = '0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic fstart(input logic [1:0] l);
    flash_start = 1'b1; flash_layer = l;
    tick();
    flash_start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    check("scoreboard_drain", sbq.size(), 0);
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL timeout: got still running required finished");
        $fatal(1, "bench timeout");
      end
    join_none

    Reset = 1'b1;
    repeat (3) tick();
    check("reset_out_valid", out_valid, 0);
    check("reset_vga", {8'h00, VGA_R, VGA_G, VGA_B}, 0);
    check("reset_flash_busy", flash_busy, 0);
    Reset = 1'b0;
    mon_en = 1'b1;

    // Cleared palette, then background lookup
    pix(4'b0000, 0, 0, 0, 0, 7, 24'h000000);
    pal_write(1'b0, 3, 24'h3FB9E9);
    pix(4'b0000, 0, 0, 0, 0, 3, 24'h3FB9E9);

    pal_write(1'b1, 2, 24'hAE3F4C);
    pal_write(1'b1, 5, 24'h00FF00);
    pal_write(1'b1, 6, 24'h00FF01);
    pix(4'b0011, 5, 2, 0, 0, 3, 24'hAE3F4C);
    pix(4'b0001, 5, 0, 0, 0, 3, 24'h3FB9E9);
    pix(4'b0001, 6, 0, 0, 0, 3, 24'h00FF01);
    pix(4'b0100, 2, 0, 6, 0, 3, 24'h00FF01);
    pix(4'b1010, 2, 5, 0, 2, 3, 24'hAE3F4C);
    pix(4'b0000, 2, 2, 2, 2, 3, 24'h3FB9E9);

    // Write and lookup of the same entry in one cycle
    pal_we = 1'b1; pal_sel = 1'b1; pal_addr = 2; pal_wdata = 24'h123456;
    pix(4'b0001, 2, 0, 0, 0, 3, 24'hAE3F4C);
    pal_we = 1'b0;
    pix(4'b0001, 2, 0, 0, 0, 3, 24'h123456);

    key_we = 1'b1; key_wdata = 24'h000000;
    tick();
    key_we = 1'b0;
    pix(4'b0001, 5, 0, 0, 0, 3, 24'h00FF00);
    pix(4'b0011, 0, 6, 0, 0, 3, 24'h00FF01);
    drain();

    // Full flash on layer 1
    fstart(2'd1);
    for (int k = FF; k >= 1; k--) begin
      check("flash_busy_span", flash_busy, 1);
      pix(4'b0010, 0, 2, 0, 0, 3, (k % 2 == 1) ? 24'hFFFFFF : 24'h123456);
      pix(4'b0011, 6, 2, 0, 0, 3, 24'h00FF01);
      frame();
    end
    check("flash_busy_end", flash_busy, 0);
    pix(4'b0010, 0, 2, 0, 0, 3, 24'h123456);
    drain();

    // Reload when flash_start meets frame_start
    fstart(2'd1);
    repeat (3) frame();
    pix(4'b0010, 0, 2, 0, 0, 3, 24'hFFFFFF);
    flash_start = 1'b1; flash_layer = 2'd1; frame_start = 1'b1;
    tick();
    flash_start = 1'b0; frame_start = 1'b0;
    pix(4'b0010, 0, 2, 0, 0, 3, 24'h123456);
    repeat (7) frame();
    check("flash_reload_busy", flash_busy, 1);
    pix(4'b0010, 0, 2, 0, 0, 3, 24'hFFFFFF);
    frame();
    check("flash_reload_end", flash_busy, 0);
    drain();

    // Reset with a flash running and a pixel in flight
    fstart(2'd1);
    frame();
    pix_valid = 1'b1; layer_hit = 4'b0010; layer_idx = {4'd0, 4'd0, 4'd2, 4'd0};
    tick();
    pix_valid = 1'b0; layer_hit = '0;
    Reset = 1'b1;
    tick();
    check("midreset_flash_busy", flash_busy, 0);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_vga", {8'h00, VGA_R, VGA_G, VGA_B}, 0);
    Reset = 1'b0;

    // Palettes cleared and key restored to its default
    pix(4'b0000, 0, 0, 0, 0, 3, 24'h000000);
    pal_write(1'b1, 1, 24'h00FF00);
    pal_write(1'b0, 0, 24'h0A0B0C);
    pix(4'b0001, 1, 0, 0, 0, 0, 24'h0A0B0C);
    drain();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
